// File: rtl/cpu_pkg.sv
// Shared types and sizing helpers for the register file / load-forwarding slice.
package cpu_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int NREGS_DEF = 16;
    // Widest register selector a load entry can carry (up to 256 registers).
    localparam int SEL_W_MAX = 8;

    typedef struct packed {
        logic                 valid;
        logic [SEL_W_MAX-1:0] dest;
    } load_entry_t;

    function automatic int sel_width(input int nregs);
        return $clog2(nregs);
    endfunction

    // A stored destination is meaningful only if its bits above sel_w are clear.
    function automatic logic dest_in_range(input logic [SEL_W_MAX-1:0] dest, input int sel_w);
        return ((dest >> sel_w) == {SEL_W_MAX{1'b0}});
    endfunction

endpackage

// File: rtl/regfile_wb_pipe_load_track.sv
// In-flight load tracker: LOAD_LATENCY-deep shift register of {valid, dest},
// pending-register mask for the non-retiring stages, and the retiring entry.
module load_track_pipe
    import cpu_pkg::*;
#(
    parameter  int NREGS        = NREGS_DEF,
    parameter  int LOAD_LATENCY = 2,
    localparam int SEL_W        = sel_width(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_i,
    input  logic [SEL_W-1:0] issue_dest_i,
    output logic [NREGS-1:0] pending_o,
    output logic             retire_valid_o,
    output logic [SEL_W-1:0] retire_dest_o,
    output logic             busy_o
);

    load_entry_t stage_q [1:LOAD_LATENCY];
    load_entry_t stage_d [1:LOAD_LATENCY];

    // The pipe advances every cycle; a stall upstream only withholds new issues.
    always_comb begin
        stage_d[1].valid = issue_i;
        stage_d[1].dest  = SEL_W_MAX'(issue_dest_i);
        for (int k = 2; k <= LOAD_LATENCY; k++) begin
            stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= LOAD_LATENCY; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= LOAD_LATENCY; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    // The retiring stage is excluded: its data is already available for bypass.
    always_comb begin
        pending_o = {NREGS{1'b0}};
        for (int k = 1; k < LOAD_LATENCY; k++) begin
            for (int r = 0; r < NREGS; r++) begin
                pending_o[r] = pending_o[r] |
                               (stage_q[k].valid && (stage_q[k].dest == SEL_W_MAX'(r)));
            end
        end
    end

    always_comb begin
        busy_o = 1'b0;
        for (int k = 1; k <= LOAD_LATENCY; k++) begin
            busy_o = busy_o | stage_q[k].valid;
        end
    end

    assign retire_valid_o = stage_q[LOAD_LATENCY].valid &&
                            dest_in_range(stage_q[LOAD_LATENCY].dest, SEL_W);
    assign retire_dest_o  = stage_q[LOAD_LATENCY].dest[SEL_W-1:0];

endmodule

// File: rtl/regfile_wb_pipe.sv
// Register file with two direct write ports, fixed-latency load write-back,
// write-first bypass and load hazard stall. Optional macro: REGFILE_ZERO_REG_EN.
module regfile_wb_pipe
    import cpu_pkg::*;
#(
    parameter  int WIDTH        = WIDTH_DEF,
    parameter  int NREGS        = NREGS_DEF,
    parameter  int LOAD_LATENCY = 2,
    localparam int SEL_W        = sel_width(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_a,
    input  logic [SEL_W-1:0] wr_sel_a,
    input  logic [WIDTH-1:0] wr_data_a,
    input  logic             wr_en_b,
    input  logic [SEL_W-1:0] wr_sel_b,
    input  logic [WIDTH-1:0] wr_data_b,
    input  logic             load_issue,
    input  logic [SEL_W-1:0] load_dest,
    input  logic [WIDTH-1:0] mem_data,
    input  logic             rd_en_a,
    input  logic             rd_en_b,
    input  logic [SEL_W-1:0] rd_sel_a,
    input  logic [SEL_W-1:0] rd_sel_b,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             stall,
    output logic             load_busy
);

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    localparam logic [SEL_W-1:0] SEL_ZERO = {SEL_W{1'b0}};

    logic [NREGS-1:0] pend_raw_s;
    logic [NREGS-1:0] pend_s;
    logic             ret_valid_s;
    logic [SEL_W-1:0] ret_dest_s;
    logic             stall_s;
    logic             issue_s;
    logic             we_a_s;
    logic             we_b_s;
    logic             ret_we_s;

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    load_track_pipe #(
        .NREGS        (NREGS),
        .LOAD_LATENCY (LOAD_LATENCY)
    ) u_track (
        .clk            (clk),
        .reset          (reset),
        .issue_i        (issue_s),
        .issue_dest_i   (load_dest),
        .pending_o      (pend_raw_s),
        .retire_valid_o (ret_valid_s),
        .retire_dest_o  (ret_dest_s),
        .busy_o         (load_busy)
    );

    assign pend_s = ZERO_REG ? (pend_raw_s & {{(NREGS-1){1'b1}}, 1'b0}) : pend_raw_s;

    assign stall_s = (rd_en_a    && pend_s[rd_sel_a])  ||
                     (rd_en_b    && pend_s[rd_sel_b])  ||
                     (wr_en_a    && pend_s[wr_sel_a])  ||
                     (wr_en_b    && pend_s[wr_sel_b])  ||
                     (load_issue && pend_s[load_dest]);
    assign stall   = stall_s;

    assign issue_s  = load_issue && !stall_s;
    assign we_a_s   = wr_en_a && !stall_s && !(ZERO_REG && (wr_sel_a == SEL_ZERO));
    assign we_b_s   = wr_en_b && !stall_s && !(ZERO_REG && (wr_sel_b == SEL_ZERO));
    assign ret_we_s = ret_valid_s && !(ZERO_REG && (ret_dest_s == SEL_ZERO));

    // Next array state with B > A > retiring load; it doubles as the bypassed read value.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = (we_b_s   && (wr_sel_b   == SEL_W'(r))) ? wr_data_b :
                        (we_a_s   && (wr_sel_a   == SEL_W'(r))) ? wr_data_a :
                        (ret_we_s && (ret_dest_s == SEL_W'(r))) ? mem_data  :
                                                                  regs_q[r];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    assign rd_data_a = (ZERO_REG && (rd_sel_a == SEL_ZERO)) ? {WIDTH{1'b0}} : regs_d[rd_sel_a];
    assign rd_data_b = (ZERO_REG && (rd_sel_b == SEL_ZERO)) ? {WIDTH{1'b0}} : regs_d[rd_sel_b];

endmodule
